seq_alu: RTL and testbench

- Multi-cycle, parametrised ALU for the CPU datapath. It replaces the combinational ALU with a registered, handshaked unit.
- Adds iterative multiply and divide, signed compare, shifts and a full status-flag set.
- The sequencer issues one operation per `start` pulse and waits for `valid` before using `result`/flags.

---
 rtl/seq_alu.sv | 237 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU behind a start/ready/valid handshake: single-cycle
// arithmetic, logic, compare and shift ops plus iterative multiply and unsigned divide.
module seq_alu #(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int CNT_WIDTH    = $clog2(DATA_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    ready,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    equal,
    output logic                    less,
    output logic                    greater,
    output logic                    zero,
    output logic                    carry,
    output logic                    overflow,
    output logic                    div_by_zero
);

    localparam int W = DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_NEG  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMPS = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_SAR  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_DIVU = OPCODE_WIDTH'(13);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         work_q;     // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [W-1:0]         divisor_q;
    logic [W-1:0]         rem_q;
    logic [2*W-1:0]       mcand_q;
    logic [2*W-1:0]       prod_q;

    logic                 accept, multi, last_iter;
    logic [W:0]           add_full, sub_full;
    logic [CNT_WIDTH-1:0] shamt;
    logic [W-1:0]         sc_result;
    logic                 sc_carry, sc_ovf, sc_eq, sc_lt, sc_gt, sc_cmp, sc_arith;
    logic [2*W-1:0]       mul_prod_nxt;
    logic [W:0]           div_shift;
    logic [W-1:0]         div_diff, div_rem_nxt, div_quo_nxt;
    logic                 div_ge;

    assign ready     = (state_q == IDLE);
    assign accept    = start && ready;
    assign multi     = (opcode == OP_MUL) || (opcode == OP_DIVU);
    assign last_iter = (cnt_q == '0);
    assign add_full  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
    assign shamt     = op_b[CNT_WIDTH-1:0];

    // One shift-add step and one restoring-divide step per cycle.
    assign mul_prod_nxt = prod_q + (work_q[0] ? mcand_q : '0);
    assign div_shift    = {rem_q, work_q[W-1]};
    assign div_ge       = div_shift >= {1'b0, divisor_q};
    assign div_diff     = W'(div_shift - {1'b0, divisor_q});
    assign div_rem_nxt  = div_ge ? div_diff : div_shift[W-1:0];
    assign div_quo_nxt  = {work_q[W-2:0], div_ge};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_eq     = 1'b0;
        sc_lt     = 1'b0;
        sc_gt     = 1'b0;
        sc_cmp    = 1'b0;
        sc_arith  = 1'b1;
        case (opcode)
            OP_ADD: begin
                sc_result = add_full[W-1:0];
                sc_carry  = add_full[W];
                sc_ovf    = (op_a[W-1] == op_b[W-1]) && (add_full[W-1] != op_a[W-1]);
            end
            OP_SUB: begin
                sc_result = sub_full[W-1:0];
                sc_carry  = sub_full[W];
                sc_ovf    = (op_a[W-1] != op_b[W-1]) && (sub_full[W-1] != op_a[W-1]);
            end
            OP_AND: sc_result = op_a & op_b;
            OP_OR:  sc_result = op_a | op_b;
            OP_XOR: sc_result = op_a ^ op_b;
            OP_NOT: sc_result = ~op_a;
            OP_NEG: begin
                sc_result = '0 - op_a;
                sc_carry  = |op_a;
                sc_ovf    = (op_a == {1'b1, {(W-1){1'b0}}});
            end
            OP_CMP, OP_CMPS: begin
                sc_result = sub_full[W-1:0];
                sc_cmp    = 1'b1;
                sc_arith  = 1'b0;
                sc_eq     = (op_a == op_b);
                sc_lt     = (opcode == OP_CMP) ? sub_full[W] : ($signed(op_a) < $signed(op_b));
                sc_gt     = !sc_eq && !sc_lt;
            end
            OP_SHL: sc_result = op_a << shamt;
            OP_SHR: sc_result = op_a >> shamt;
            OP_SAR: sc_result = $signed(op_a) >>> shamt;
            default: sc_arith = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && opcode == OP_MUL) begin
                    state_d = MUL_RUN;
                end else if (accept && opcode == OP_DIVU) begin
                    state_d = (op_b == '0) ? DONE : DIV_RUN;
                end
            end
            MUL_RUN, DIV_RUN: if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Visible outputs are written only on the edge that also raises valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            valid       <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            equal       <= 1'b0;
            less        <= 1'b0;
            greater     <= 1'b0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    work_q    <= op_a;
                    divisor_q <= op_b;
                    mcand_q   <= {{W{1'b0}}, op_b};
                    prod_q    <= '0;
                    rem_q     <= '0;
                    cnt_q     <= CNT_WIDTH'(W - 1);
                    if (opcode == OP_DIVU && op_b == '0) begin
                        valid       <= 1'b1;
                        result      <= '1;
                        remainder   <= op_a;
                        div_by_zero <= 1'b1;
                        zero        <= 1'b0;
                        carry       <= 1'b0;
                        overflow    <= 1'b0;
                    end else if (!multi) begin
                        valid       <= 1'b1;
                        result      <= sc_result;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        if (sc_arith) begin
                            zero     <= (sc_result == '0);
                            carry    <= sc_carry;
                            overflow <= sc_ovf;
                        end
                        if (sc_cmp) begin
                            equal   <= sc_eq;
                            less    <= sc_lt;
                            greater <= sc_gt;
                        end
                    end
                end
                MUL_RUN: begin
                    prod_q  <= mul_prod_nxt;
                    mcand_q <= mcand_q << 1;
                    work_q  <= work_q >> 1;
                    if (last_iter) begin
                        valid       <= 1'b1;
                        result      <= mul_prod_nxt[W-1:0];
                        remainder   <= '0;
                        zero        <= (mul_prod_nxt[W-1:0] == '0);
                        carry       <= |mul_prod_nxt[2*W-1:W];
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                DIV_RUN: begin
                    rem_q  <= div_rem_nxt;
                    work_q <= div_quo_nxt;
                    if (last_iter) begin
                        valid       <= 1'b1;
                        result      <= div_quo_nxt;
                        remainder   <= div_rem_nxt;
                        zero        <= (div_quo_nxt == '0);
                        carry       <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random ops compared
// against an arithmetic reference model of the ALU's observable behaviour.
module tb_seq_alu;

    localparam int     W     = 16;
    localparam int     CW    = $clog2(W + 1);
    localparam int     OBS_W = 2 * W + 7;
    localparam longint MOD   = longint'(1) << W;
    localparam longint MASK  = MOD - 1;
    localparam longint HALF  = MOD >> 1;

    typedef logic [OBS_W-1:0] obs_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] op_a, op_b;
    logic         ready, valid;
    logic [W-1:0] result, remainder;
    logic         equal, less, greater, zero, carry, overflow, div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs should show after the last completed op.
    logic [W-1:0] m_res, m_rem;
    bit           m_eq, m_lt, m_gt, m_z, m_c, m_v, m_dbz;
    int           m_lat;

    seq_alu #(.DATA_WIDTH(W), .OPCODE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op_a(op_a), .op_b(op_b),
        .ready(ready), .valid(valid), .result(result), .remainder(remainder),
        .equal(equal), .less(less), .greater(greater), .zero(zero), .carry(carry),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t snap();
        return {result, remainder, equal, less, greater, zero, carry, overflow, div_by_zero};
    endfunction

    function automatic obs_t model_vec();
        return {m_res, m_rem, m_eq, m_lt, m_gt, m_z, m_c, m_v, m_dbz};
    endfunction

    function automatic longint sext(longint x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    function automatic longint pick();
        case ($urandom_range(7, 0))
            0: return 0;
            1: return HALF;
            2: return MASK;
            3: return HALF - 1;
            default: return longint'($urandom() & 32'hFFFF);
        endcase
    endfunction

    task automatic model_reset();
        m_res = '0; m_rem = '0; m_lat = 1;
        {m_eq, m_lt, m_gt, m_z, m_c, m_v, m_dbz} = '0;
    endtask

    task automatic model_op(input int op, input longint a, input longint b);
        longint r, sa, sb, n;
        sa = sext(a);
        sb = sext(b);
        n  = b % (longint'(1) << CW);
        r  = 0;
        m_rem = '0;
        m_dbz = 1'b0;
        m_lat = 1;
        case (op)
            0: begin r = a + b; m_c = (r >= MOD); m_v = (sa + sb >= HALF) || (sa + sb < -HALF); end
            1: begin r = a - b; m_c = (a < b);    m_v = (sa - sb >= HALF) || (sa - sb < -HALF); end
            2: begin r = a * b; m_c = (r >= MOD); m_v = 1'b0; m_lat = W + 1; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = MASK - a;
            7: begin r = -a; m_c = (a != 0); m_v = (a == HALF); end
            8, 9: begin
                r    = a - b;
                m_eq = (a == b);
                m_lt = (op == 8) ? (a < b) : (sa < sb);
                m_gt = (op == 8) ? (a > b) : (sa > sb);
            end
            10: r = (n >= W) ? 0 : (a << n);
            11: r = a >> n;
            12: r = sa >>> n;
            13: begin
                m_c = 1'b0;
                m_v = 1'b0;
                if (b == 0) begin
                    r = MASK; m_rem = a[W-1:0]; m_dbz = 1'b1;
                end else begin
                    r = a / b; m_rem = W'(a % b); m_lat = W + 1;
                end
            end
            default: r = 0;
        endcase
        if (op inside {3, 4, 5, 6, 10, 11, 12}) begin
            m_c = 1'b0;
            m_v = 1'b0;
        end
        m_res = r[W-1:0];
        if (op <= 7 || (op >= 10 && op <= 13)) m_z = (m_res == '0);
    endtask

    // Issues one op once ready is high and returns the accept-to-valid latency (999 on timeout).
    task automatic run_op(input int op, input longint a, input longint b, output int lat);
        int guard = 0;
        while (!ready && guard < 64) begin
            @(posedge clk); #1; guard++;
        end
        if (!ready) begin
            lat = 999;
            return;
        end
        start = 1'b1; opcode = op[3:0]; op_a = a[W-1:0]; op_b = b[W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        if (!valid) lat = 999;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; opcode = '0; op_a = '0; op_b = '0;
        model_reset();
        #1;
        n_vec++;
        if ({ready, valid, snap()} !== {1'b1, 1'b0, obs_t'(0)}) begin
            n_err++;
            $display("FAIL reset_state: got %h required %h", {ready, valid, snap()}, {1'b1, 1'b0, obs_t'(0)});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({ready, valid} !== 2'b10) begin
            n_err++;
            $display("FAIL post_reset_idle: ready/valid got %b required 10", {ready, valid});
        end
    endtask

    task automatic test_add_sub_cmp();
        int     ops[3] = '{0, 1, 9};
        longint as[3]  = '{'h7FFF, 'h0003, 'hFFFE};
        longint bs[3]  = '{'h0001, 'h0005, 'h0001};
        int     lat;
        for (int i = 0; i < 3; i++) begin
            model_op(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], lat);
            n_vec++;
            if (lat != m_lat) begin
                n_err++;
                $display("FAIL arith_latency op=%0d: got %0d required %0d", ops[i], lat, m_lat);
            end
            n_vec++;
            if (snap() !== model_vec()) begin
                n_err++;
                $display("FAIL arith_outputs op=%0d: got %h required %h", ops[i], snap(), model_vec());
            end
        end
    endtask

    task automatic test_mul();
        int lat;
        model_op(2, 'h0123, 'h0045);
        start = 1'b1; opcode = 4'd2; op_a = 16'h0123; op_b = 16'h0045;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 64) begin
            // A start raised mid-run must be dropped, not queued.
            if (lat == 5) begin
                start = 1'b1; opcode = 4'd0; op_a = 16'h0001; op_b = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        start = 1'b0;
        n_vec++;
        if (lat != m_lat) begin
            n_err++;
            $display("FAIL mul_latency: got %0d required %0d", lat, m_lat);
        end
        n_vec++;
        if ({ready, snap()} !== {1'b0, model_vec()}) begin
            n_err++;
            $display("FAIL mul_outputs: got %h required %h", {ready, snap()}, {1'b0, model_vec()});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({ready, valid} !== 2'b10) begin
            n_err++;
            $display("FAIL mul_ignored_start: ready/valid got %b required 10", {ready, valid});
        end
    endtask

    task automatic test_divu();
        longint as[2] = '{1000, 5};
        longint bs[2] = '{7, 0};
        int     lat;
        for (int i = 0; i < 2; i++) begin
            model_op(13, as[i], bs[i]);
            run_op(13, as[i], bs[i], lat);
            n_vec++;
            if (lat != m_lat) begin
                n_err++;
                $display("FAIL divu_latency b=%0d: got %0d required %0d", bs[i], lat, m_lat);
            end
            n_vec++;
            if (snap() !== model_vec()) begin
                n_err++;
                $display("FAIL divu_outputs b=%0d: got %h required %h", bs[i], snap(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int     ops[3] = '{5, 10, 12};
        longint as[3]  = '{'hA5A5, 'h1234, 'h8000};
        longint bs[3]  = '{'h0FF0, 4, 20};
        int     guard  = 0;
        while (!ready && guard < 64) begin
            @(posedge clk); #1; guard++;
        end
        for (int i = 0; i < 3; i++) begin
            model_op(ops[i], as[i], bs[i]);
            start = 1'b1; opcode = ops[i][3:0]; op_a = as[i][W-1:0]; op_b = bs[i][W-1:0];
            @(posedge clk); #1;
            n_vec++;
            if ({ready, valid, snap()} !== {1'b1, 1'b1, model_vec()}) begin
                n_err++;
                $display("FAIL back_to_back op=%0d: got %h required %h",
                         ops[i], {ready, valid, snap()}, {1'b1, 1'b1, model_vec()});
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_tail: valid got %b required 0", valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stale = 0;
        start = 1'b1; opcode = 4'd2; op_a = 16'hBEEF; op_b = 16'h1357;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({ready, valid, snap()} !== {1'b1, 1'b0, model_vec()}) begin
            n_err++;
            $display("FAIL reset_mid_mul: got %h required %h", {ready, valid, snap()}, {1'b1, 1'b0, model_vec()});
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (valid || !ready) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL reset_stale_valid: bad cycles got %0d required 0", stale);
        end
    endtask

    task automatic test_random();
        int     op, lat;
        longint a, b;
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(15, 0));
            a  = pick();
            b  = pick();
            model_op(op, a, b);
            run_op(op, a, b, lat);
            n_vec++;
            if (lat != m_lat) begin
                n_err++;
                $display("FAIL random_latency op=%0d a=%h b=%h: got %0d required %0d", op, a, b, lat, m_lat);
            end
            n_vec++;
            if (snap() !== model_vec()) begin
                n_err++;
                $display("FAIL random_outputs op=%0d a=%h b=%h: got %h required %h", op, a, b, snap(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub_cmp();
        test_mul();
        test_divu();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
